hpdcache_sram_wbe_req_ctrl: RTL and testbench

// - Request-side controller sitting directly upstream of the 1RW byte-enable SRAM wrapper
//   (hpdcache_sram_wbyteenable).
// - Converts a valid/ready request stream into SRAM cs/we/addr/wdata/wbyteenable strobes.
// - Returns read data on a valid/ready response channel with backpressure.
// - Guarantees no read response is lost: reads are credit-gated against a small response FIFO.
//

---
 rtl/hpdcache_sram_wbe_req_ctrl_pkg.sv | 16 +
 rtl/hpdcache_sram_rsp_fifo.sv | 64 ++++++
 rtl/hpdcache_sram_wbe_req_ctrl.sv | 89 ++++++++
 tb/tb_hpdcache_sram_wbe_req_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_sram_wbe_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_wbe_req_ctrl_pkg
// Description : Shared helpers for the SRAM request controller and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package hpdcache_sram_wbe_req_ctrl_pkg;

  // Modulo increment that works for any depth, not only powers of two
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned depth);
    return ((ptr + 32'd1) >= depth) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_rsp_fifo
// Description : Parameterised register FIFO holding read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_sram_rsp_fifo
  import hpdcache_sram_wbe_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= PTR_W'(wrap_inc(32'(r_wr_ptr), DEPTH));
      end
      if (pop) begin
        r_rd_ptr <= PTR_W'(wrap_inc(32'(r_rd_ptr), DEPTH));
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_sram_wbe_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_wbe_req_ctrl
// Description : Valid/ready request front-end for a 1RW byte-enable SRAM with
//               credit-gated, in-order read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_sram_wbe_req_ctrl
  import hpdcache_sram_wbe_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_SIZE-1:0]   req_addr_i,
  input  logic [DATA_SIZE-1:0]   req_wdata_i,
  input  logic [DATA_SIZE/8-1:0] req_wbe_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_SIZE-1:0]   rsp_rdata_o,
  output logic                   sram_cs_o,
  output logic                   sram_we_o,
  output logic [ADDR_SIZE-1:0]   sram_addr_o,
  output logic [DATA_SIZE-1:0]   sram_wdata_o,
  output logic [DATA_SIZE/8-1:0] sram_wbyteenable_o,
  input  logic [DATA_SIZE-1:0]   sram_rdata_i
);

  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);

  logic                 r_rd_inflight;
  logic                 w_req_fire;
  logic                 w_rd_fire;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [OCC_W-1:0]     w_fifo_count;
  logic [OCC_W-1:0]     w_occupancy;
  logic [DATA_SIZE-1:0] w_fifo_rdata;

  // A read holds its credit from acceptance until its response is popped
  assign w_occupancy = w_fifo_count + OCC_W'(r_rd_inflight);
  assign req_ready_o = req_we_i | (w_occupancy < OCC_W'(RSP_DEPTH));
  assign w_req_fire  = req_valid_i & req_ready_o;
  assign w_rd_fire   = w_req_fire & ~req_we_i;

  assign sram_cs_o          = w_req_fire;
  assign sram_we_o          = req_we_i;
  assign sram_addr_o        = req_addr_i;
  assign sram_wdata_o       = req_wdata_i;
  assign sram_wbyteenable_o = req_we_i ? req_wbe_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_rd_fire;
    end
  end

  // SRAM data bypasses the FIFO only when nothing older is queued
  assign rsp_valid_o = r_rd_inflight | ~w_fifo_empty;
  assign rsp_rdata_o = w_fifo_empty ? sram_rdata_i : w_fifo_rdata;
  assign w_pop       = ~w_fifo_empty & rsp_ready_i;
  assign w_push      = r_rd_inflight & ~(w_fifo_empty & rsp_ready_i);

  hpdcache_sram_rsp_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push & ~w_fifo_full),
    .pop   (w_pop),
    .wdata (sram_rdata_i),
    .rdata (w_fifo_rdata),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_sram_wbe_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hpdcache_sram_wbe_req_ctrl
// Description : Self-checking bench with SRAM model and response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdcache_sram_wbe_req_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [BW-1:0] req_wbe_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          sram_cs_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [BW-1:0] sram_wbyteenable_o;
  logic [DW-1:0] sram_rdata_i = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hpdcache_sram_wbe_req_ctrl #(
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_we_i           (req_we_i),
    .req_addr_i         (req_addr_i),
    .req_wdata_i        (req_wdata_i),
    .req_wbe_i          (req_wbe_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_rdata_o        (rsp_rdata_o),
    .sram_cs_o          (sram_cs_o),
    .sram_we_o          (sram_we_o),
    .sram_addr_o        (sram_addr_o),
    .sram_wdata_o       (sram_wdata_o),
    .sram_wbyteenable_o (sram_wbyteenable_o),
    .sram_rdata_i       (sram_rdata_i)
  );

  // 1RW byte-enable SRAM: read data appears the cycle after the read
  logic [DW-1:0] sram_mem [64];
  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < BW; b++)
          if (sram_wbyteenable_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  // Reference: memory contents plus the list of responses owed, oldest first
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q [$];

  logic          obs_ready, obs_rsp_valid, obs_cs, obs_we, obs_ovf;
  logic [BW-1:0] obs_wbe;
  logic [DW-1:0] obs_rdata;
  logic          exp_ready, exp_rsp_valid;
  logic [DW-1:0] exp_rdata;

  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, input logic rr);
    @(negedge clk);
    req_valid_i = v; req_we_i = we; req_addr_i = a;
    req_wdata_i = d; req_wbe_i = be; rsp_ready_i = rr;
    #1;
    obs_ready = req_ready_o; obs_rsp_valid = rsp_valid_o; obs_rdata = rsp_rdata_o;
    obs_cs = sram_cs_o; obs_we = sram_we_o; obs_wbe = sram_wbyteenable_o;
    obs_ovf = dut.w_push & dut.w_fifo_full;
    exp_ready     = we | (exp_q.size() < DEPTH);
    exp_rsp_valid = (exp_q.size() != 0);
    exp_rdata     = exp_rsp_valid ? exp_q[0] : '0;
    if (exp_rsp_valid && rr) void'(exp_q.pop_front());
    if (v && exp_ready) begin
      if (we) begin
        for (int b = 0; b < BW; b++)
          if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic test_reset();
    req_valid_i = 1'b0; req_we_i = 1'b0; rst = 1'b1;
    #1;
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
    tests++; if (sram_cs_o !== 1'b0) begin fails++; $display("FAIL reset_cs got=%b exp=0", sram_cs_o); end
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    @(negedge clk); rst = 1'b0; exp_q.delete();
  endtask

  task automatic test_write_read();
    cycle(1'b1, 1'b1, 6'h05, 64'h1122334455667788, 8'hFF, 1'b1);
    tests++; if (obs_cs !== 1'b1 || obs_we !== 1'b1 || obs_wbe !== 8'hFF) begin
      fails++; $display("FAIL wr_strobes got cs=%b we=%b wbe=%h exp 1 1 ff", obs_cs, obs_we, obs_wbe); end
    cycle(1'b1, 1'b0, 6'h05, '0, 8'hFF, 1'b1);
    tests++; if (obs_cs !== 1'b1 || obs_we !== 1'b0 || obs_wbe !== 8'h00) begin
      fails++; $display("FAIL rd_strobes got cs=%b we=%b wbe=%h exp 1 0 00", obs_cs, obs_we, obs_wbe); end
    tests++; if (obs_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_early_valid got=%b exp=0", obs_rsp_valid); end
    idle(1'b1);
    tests++; if (obs_rsp_valid !== 1'b1) begin fails++; $display("FAIL rd_latency got=%b exp=1", obs_rsp_valid); end
    tests++; if (obs_rdata !== 64'h1122334455667788) begin
      fails++; $display("FAIL rd_data got=%h exp=1122334455667788", obs_rdata); end
  endtask

  task automatic test_partial_write();
    cycle(1'b1, 1'b1, 6'h05, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b1);
    cycle(1'b1, 1'b0, 6'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    tests++; if (obs_wbe !== 8'h00) begin fails++; $display("FAIL pw_rd_wbe got=%h exp=00", obs_wbe); end
    idle(1'b1);
    tests++; if (obs_rsp_valid !== 1'b1 || obs_rdata !== 64'h11223344_BBBBBBBB) begin
      fails++; $display("FAIL pw_data got v=%b d=%h exp v=1 d=11223344bbbbbbbb", obs_rsp_valid, obs_rdata); end
  endtask

  task automatic test_credit_stall();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, AW'(8 + i), {$urandom, $urandom}, 8'hFF, 1'b1);
    cycle(1'b1, 1'b0, 6'd8, '0, '0, 1'b0);
    tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL stall_rd0_ready got=%b exp=1", obs_ready); end
    cycle(1'b1, 1'b0, 6'd9, '0, '0, 1'b0);
    tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL stall_rd1_ready got=%b exp=1", obs_ready); end
    cycle(1'b1, 1'b0, 6'd10, '0, '0, 1'b0);
    tests++; if (obs_ready !== 1'b0 || obs_cs !== 1'b0) begin
      fails++; $display("FAIL stall_rd2_blocked got ready=%b cs=%b exp 0 0", obs_ready, obs_cs); end
    tests++; if (obs_rsp_valid !== 1'b1 || obs_rdata !== exp_rdata) begin
      fails++; $display("FAIL stall_head got v=%b d=%h exp v=1 d=%h", obs_rsp_valid, obs_rdata, exp_rdata); end
    cycle(1'b1, 1'b1, 6'd20, {$urandom, $urandom}, 8'hFF, 1'b0);
    tests++; if (obs_ready !== 1'b1 || obs_cs !== 1'b1) begin
      fails++; $display("FAIL stall_write got ready=%b cs=%b exp 1 1", obs_ready, obs_cs); end
    cycle(1'b1, 1'b0, 6'd10, '0, '0, 1'b1);
    tests++; if (obs_ready !== 1'b0 || obs_rdata !== exp_rdata) begin
      fails++; $display("FAIL drain0 got ready=%b d=%h exp 0 %h", obs_ready, obs_rdata, exp_rdata); end
    cycle(1'b1, 1'b0, 6'd10, '0, '0, 1'b1);
    tests++; if (obs_ready !== 1'b1 || obs_rdata !== exp_rdata) begin
      fails++; $display("FAIL drain1 got ready=%b d=%h exp 1 %h", obs_ready, obs_rdata, exp_rdata); end
    idle(1'b1);
    tests++; if (obs_rsp_valid !== 1'b1 || obs_rdata !== exp_rdata) begin
      fails++; $display("FAIL drain2 got v=%b d=%h exp 1 %h", obs_rsp_valid, obs_rdata, exp_rdata); end
    idle(1'b1);
    tests++; if (obs_rsp_valid !== 1'b0) begin fails++; $display("FAIL drain_done got=%b exp=0", obs_rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, AW'(i), {$urandom, $urandom}, 8'hFF, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      cycle(i < 16, 1'b0, AW'(i), '0, '0, 1'b1);
      if (i < 16) begin
        tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, obs_ready); end
      end
      if (i > 0) begin
        if (obs_rsp_valid === 1'b1) nvalid++;
        tests++; if (obs_rsp_valid !== 1'b1 || obs_rdata !== exp_rdata) begin
          fails++; $display("FAIL stream_rsp[%0d] got v=%b d=%h exp 1 %h", i, obs_rsp_valid, obs_rdata, exp_rdata); end
      end
    end
    tests++; if (nvalid != 16) begin fails++; $display("FAIL stream_count got=%0d exp=16", nvalid); end
  endtask

  task automatic test_random();
    int accepted = 0;
    int cyc = 0;
    logic v, we, rr;
    while (accepted < 1000 && cyc < 20000) begin
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) != 0;
      rr = $urandom_range(0, 2) != 0;
      cycle(v, we, AW'($urandom_range(0, 15)), {$urandom, $urandom}, BW'($urandom), rr);
      tests++; if (obs_ready !== exp_ready || obs_cs !== (v & exp_ready)) begin
        fails++; $display("FAIL rnd_ready cyc=%0d got r=%b cs=%b exp r=%b cs=%b", cyc, obs_ready, obs_cs, exp_ready, v & exp_ready); end
      tests++; if (obs_rsp_valid !== exp_rsp_valid || (exp_rsp_valid && obs_rdata !== exp_rdata)) begin
        fails++; $display("FAIL rnd_rsp cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, obs_rsp_valid, obs_rdata, exp_rsp_valid, exp_rdata); end
      tests++; if (obs_ovf !== 1'b0) begin fails++; $display("FAIL fifo_overflow cyc=%0d got=%b exp=0", cyc, obs_ovf); end
      if (v && exp_ready) accepted++;
      cyc++;
    end
    tests++; if (accepted != 1000) begin fails++; $display("FAIL rnd_timeout got=%0d exp=1000", accepted); end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      tests++; if (obs_rsp_valid !== exp_rsp_valid || (exp_rsp_valid && obs_rdata !== exp_rdata)) begin
        fails++; $display("FAIL rnd_drain got v=%b d=%h exp v=%b d=%h", obs_rsp_valid, obs_rdata, exp_rsp_valid, exp_rdata); end
    end
  endtask

  task automatic test_reset_midop();
    cycle(1'b1, 1'b1, 6'd7, {$urandom, $urandom}, 8'hFF, 1'b0);
    cycle(1'b1, 1'b0, 6'd3, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 6'd4, '0, '0, 1'b0);
    @(negedge clk);
    req_valid_i = 1'b0; req_we_i = 1'b0;
    #1;
    tests++; if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
      fails++; $display("FAIL pre_reset got v=%b ready=%b exp 1 0", rsp_valid_o, req_ready_o); end
    #1 rst = 1'b1;
    #1;
    tests++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      fails++; $display("FAIL async_reset got v=%b ready=%b exp 0 1", rsp_valid_o, req_ready_o); end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    cycle(1'b1, 1'b0, 6'd7, '0, '0, 1'b1);
    tests++; if (obs_ready !== 1'b1 || obs_rsp_valid !== 1'b0) begin
      fails++; $display("FAIL post_reset_rd got ready=%b v=%b exp 1 0", obs_ready, obs_rsp_valid); end
    idle(1'b1);
    tests++; if (obs_rsp_valid !== 1'b1 || obs_rdata !== exp_rdata) begin
      fails++; $display("FAIL post_reset_rsp got v=%b d=%h exp 1 %h", obs_rsp_valid, obs_rdata, exp_rdata); end
    idle(1'b1);
    tests++; if (obs_rsp_valid !== 1'b0) begin fails++; $display("FAIL post_reset_single got=%b exp=0", obs_rsp_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    test_reset();
    test_write_read();
    test_partial_write();
    test_credit_stall();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
